// File: rtl/reaction_timer_pkg.sv
// rtl/reaction_timer_pkg.sv - shared types and constants for the reaction timer
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TIMING,
    DONE,
    FAULT
  } state_t;

  localparam int DEF_TIME_W = 14;
  localparam int DEF_MAX_MS = 9999;
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/reaction_timer_if.sv
// rtl/reaction_timer_if.sv - control/result bundle between starting-line logic and the timer
interface reaction_timer_if #(
  parameter int TIME_W = 14
);
  logic              i_tickMs;
  logic              i_arm;
  logic              i_go;
  logic              i_response;
  logic              i_clear;
  logic [TIME_W-1:0] o_time;
  logic              o_valid;
  logic              o_falseStart;
  logic              o_timeout;
  logic              o_busy;
  logic [TIME_W-1:0] o_best;

  modport master (
    output i_tickMs, i_arm, i_go, i_response, i_clear,
    input  o_time, o_valid, o_falseStart, o_timeout, o_busy, o_best
  );

  modport slave (
    input  i_tickMs, i_arm, i_go, i_response, i_clear,
    output o_time, o_valid, o_falseStart, o_timeout, o_busy, o_best
  );
endinterface

// File: rtl/reaction_timer_sync_rise.sv
// rtl/reaction_timer_sync_rise.sv - DEPTH-flop synchronizer with a registered rising-edge pulse
// DEPTH=0 skips synchronization for inputs already in the clock domain.
module sync_rise #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic sampled;
  logic prev;

  generate
    if (DEPTH == 0) begin : g_direct
      assign sampled = d;
    end else begin : g_sync
      logic [DEPTH-1:0] sync_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign sampled = sync_q[DEPTH-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= sampled;
      rise <= sampled & ~prev;
    end
  end
endmodule

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - racer reaction time measurement with false-start and timeout flags
// Optional best-time tracking is enabled by defining REACTION_TIMER_BEST_EN.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int MAX_MS = DEF_MAX_MS,
  parameter int TIME_W = DEF_TIME_W
) (
  input  logic             i_clk,
  input  logic             i_arst,
  reaction_timer_if.slave  bus
);
  localparam logic [TIME_W-1:0] MAX_T  = TIME_W'(MAX_MS);
  localparam logic [TIME_W-1:0] LAST_T = TIME_W'(MAX_MS - 1);

  state_t            state;
  logic [TIME_W-1:0] count;
  logic [TIME_W-1:0] time_q;
  logic              valid_q;
  logic              false_start_q;
  logic              timeout_q;
  logic              busy_q;
  logic              rsp;
  logic              go;
  logic              capture;

  sync_rise #(.DEPTH(SYNC_DEPTH)) u_rsp_sync (
    .clk  (i_clk),
    .rst  (i_arst),
    .d    (bus.i_response),
    .rise (rsp)
  );

  sync_rise #(.DEPTH(0)) u_go_edge (
    .clk  (i_clk),
    .rst  (i_arst),
    .d    (bus.i_go),
    .rise (go)
  );

  // A valid result is latched only when no clear/arm overrides the response.
  assign capture = (state == TIMING) && rsp && !bus.i_clear && !bus.i_arm;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state         <= IDLE;
      count         <= '0;
      time_q        <= '0;
      valid_q       <= 1'b0;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else if (bus.i_clear) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else if (bus.i_arm) begin
      state         <= ARMED;
      count         <= '0;
      valid_q       <= 1'b0;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      case (state)
        ARMED: begin
          if (rsp) begin
            state         <= FAULT;
            false_start_q <= 1'b1;
            busy_q        <= 1'b0;
          end else if (go) begin
            state <= TIMING;
            count <= '0;
          end
        end
        TIMING: begin
          if (capture) begin
            state   <= DONE;
            time_q  <= count;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (bus.i_tickMs) begin
            if (count >= LAST_T) begin
              state     <= DONE;
              count     <= MAX_T;
              time_q    <= MAX_T;
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REACTION_TIMER_BEST_EN
  logic [TIME_W-1:0] best_q;
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      best_q <= MAX_T;
    end else if (capture && (count < best_q)) begin
      best_q <= count;
    end
  end
  assign bus.o_best = best_q;
`else
  assign bus.o_best = MAX_T;
`endif

  assign bus.o_time       = time_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_falseStart = false_start_q;
  assign bus.o_timeout    = timeout_q;
  assign bus.o_busy       = busy_q;
endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - directed table-driven bench for reaction_timer
module tb_reaction_timer;
  localparam int TW = 14;
  localparam int MX = 9999;
  localparam bit BEST_EN =
`ifdef REACTION_TIMER_BEST_EN
    1'b1;
`else
    1'b0;
`endif

  typedef enum int { M_NORMAL, M_COINCIDE, M_FALSE, M_SIMUL, M_TIMEOUT } mode_t;

  typedef struct {
    mode_t mode;
    int    n;
    int    exp_time;
    int    exp_valid;
    int    exp_fs;
    int    exp_to;
    int    exp_best;
  } vec_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  int   passed = 0;
  int   total = 0;
  vec_t vecs[8];

  reaction_timer_if #(.TIME_W(TW)) bus ();

  reaction_timer #(.MAX_MS(MX), .TIME_W(TW)) dut (
    .i_clk  (clk),
    .i_arst (arst),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input int t, input int v, input int fs,
                            input int to, input int busy, input int best);
    chk({tag, ".time"}, int'(bus.o_time), t);
    chk({tag, ".valid"}, int'(bus.o_valid), v);
    chk({tag, ".false_start"}, int'(bus.o_falseStart), fs);
    chk({tag, ".timeout"}, int'(bus.o_timeout), to);
    chk({tag, ".busy"}, int'(bus.o_busy), busy);
    chk({tag, ".best"}, int'(bus.o_best), best);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_tickMs = 1'b1;
      @(negedge clk);
      bus.i_tickMs = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic arm();
    bus.i_arm = 1'b1;
    @(negedge clk);
    bus.i_arm = 1'b0;
  endtask

  task automatic start_timing();
    arm();
    bus.i_go = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_inputs();
    bus.i_go = 1'b0;
    bus.i_response = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    case (v.mode)
      M_NORMAL: begin
        start_timing();
        ticks(v.n);
        bus.i_response = 1'b1;
        repeat (5) @(negedge clk);
      end
      M_COINCIDE: begin
        start_timing();
        ticks(v.n);
        bus.i_response = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_tickMs = 1'b1;
        @(negedge clk);
        bus.i_tickMs = 1'b0;
        repeat (2) @(negedge clk);
      end
      M_FALSE: begin
        arm();
        bus.i_response = 1'b1;
        repeat (5) @(negedge clk);
        check_outs({tag, ".pre_go"}, v.exp_time, v.exp_valid, v.exp_fs, v.exp_to, 0, v.exp_best);
        bus.i_go = 1'b1;
        repeat (4) @(negedge clk);
      end
      M_SIMUL: begin
        arm();
        bus.i_response = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_go = 1'b1;
        repeat (4) @(negedge clk);
      end
      default: begin
        start_timing();
        ticks(v.n);
        repeat (2) @(negedge clk);
      end
    endcase
    check_outs(tag, v.exp_time, v.exp_valid, v.exp_fs, v.exp_to, 0, v.exp_best);
    release_inputs();
  endtask

  initial begin
    vecs[0] = '{M_NORMAL,   300, 300, 1, 0, 0, BEST_EN ? 300 : MX};
    vecs[1] = '{M_NORMAL,   180, 180, 1, 0, 0, BEST_EN ? 180 : MX};
    vecs[2] = '{M_NORMAL,   220, 220, 1, 0, 0, BEST_EN ? 180 : MX};
    vecs[3] = '{M_NORMAL,   250, 250, 1, 0, 0, BEST_EN ? 180 : MX};
    vecs[4] = '{M_COINCIDE,  99,  99, 1, 0, 0, BEST_EN ? 99 : MX};
    vecs[5] = '{M_FALSE,      0,  99, 0, 1, 0, BEST_EN ? 99 : MX};
    vecs[6] = '{M_SIMUL,      0,  99, 0, 1, 0, BEST_EN ? 99 : MX};
    vecs[7] = '{M_TIMEOUT,   MX,  MX, 0, 0, 1, BEST_EN ? 99 : MX};

    bus.i_tickMs = 1'b0;
    bus.i_arm = 1'b0;
    bus.i_go = 1'b0;
    bus.i_response = 1'b0;
    bus.i_clear = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0, MX);
    arst = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("idle", 0, 0, 0, 0, 0, MX);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Clear returns to idle but keeps the last result visible.
    bus.i_clear = 1'b1;
    @(negedge clk);
    bus.i_clear = 1'b0;
    @(negedge clk);
    check_outs("clear", MX, 0, 0, 1, 0, BEST_EN ? 99 : MX);

    // Clear beats a simultaneous arm.
    bus.i_clear = 1'b1;
    bus.i_arm = 1'b1;
    @(negedge clk);
    bus.i_clear = 1'b0;
    bus.i_arm = 1'b0;
    @(negedge clk);
    chk("clear_over_arm.busy", int'(bus.o_busy), 0);
    chk("clear_over_arm.timeout", int'(bus.o_timeout), 1);

    // Asynchronous reset in the middle of timing.
    start_timing();
    ticks(40);
    chk("mid_timing.busy", int'(bus.o_busy), 1);
    #3 arst = 1'b1;
    #1 check_outs("async_reset", 0, 0, 0, 0, 0, MX);
    @(negedge clk);
    arst = 1'b0;
    release_inputs();
    start_timing();
    ticks(120);
    bus.i_response = 1'b1;
    repeat (5) @(negedge clk);
    check_outs("after_reset", 120, 1, 0, 0, 0, BEST_EN ? 120 : MX);
    release_inputs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reaction_timer.md
# reaction_timer

Measures the racer's reaction time for the starting-line circuit. The block arms when the starting-line FSM begins its random delay, counts milliseconds from the moment the lights come on until the racer presses the response key, and flags a false start if the key is pressed before the lights. It runs in the 50 MHz domain using the existing 1 ms tick as a count enable, and its result feeds the 7-segment BCD display path.

## Interface
Parameters:
- MAX_MS, 9999: saturation and timeout value in ms; must fit in TIME_W bits.
- TIME_W, 14: width of the time outputs.

Ports:
- i_clk  in  1  single clock (CLOCK_50).
- i_arst  in  1  asynchronous, active-high reset.
- i_tickMs  in  1  1 ms enable strobe, one i_clk cycle wide.
- i_arm  in  1  one-cycle pulse; starts a new measurement (driven by the starting-line FSM's delay start).
- i_go  in  1  level; the lights are on (delay complete). Only its rising edge is used.
- i_response  in  1  racer key, active high, asynchronous to i_clk.
- i_clear  in  1  one-cycle pulse; returns the block to IDLE and keeps the outputs.
- o_time  out  TIME_W  last measured reaction time in ms.
- o_valid  out  1  o_time holds a completed measurement.
- o_falseStart  out  1  key pressed before the lights.
- o_timeout  out  1  no response within MAX_MS.
- o_busy  out  1  state is ARMED or TIMING.
- o_best  out  TIME_W  best (minimum) valid time; see Configuration.

## Operation
- i_response passes through a 2-flop synchronizer followed by a rising-edge detector, which produces `rsp`. i_go uses a 1-flop rising-edge detector only (it is already synchronous), which produces `go`.
- States:
  - IDLE:
    - i_arm → ARMED. The count is cleared, and o_valid, o_falseStart and o_timeout are cleared.
  - ARMED:
    - `rsp` → FAULT with o_falseStart=1.
    - Otherwise `go` → TIMING with count=0.
    - `rsp` and `go` in the same cycle → FAULT (false start wins).
  - TIMING:
    - On i_tickMs, count += 1.
    - On `rsp` → DONE. o_time = count, o_valid=1. If `rsp` and i_tickMs occur in the same cycle, the increment is not applied.
    - When count reaches MAX_MS → DONE with o_time=MAX_MS, o_timeout=1, o_valid=0.
  - DONE, FAULT:
    - Hold all outputs.
    - i_arm → ARMED (clears the flags as above).
    - i_clear → IDLE.
- i_arm in ARMED or TIMING restarts the measurement at ARMED, with count and flags cleared.
- i_clear takes priority over i_arm in every state.
- The count saturates and never wraps.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values.

## Timing
- Reset values:
  - State IDLE.
  - o_time=0, o_valid=0, o_falseStart=0, o_timeout=0, o_busy=0.
  - o_best=MAX_MS.
  - Synchronizer and edge flops 0.
- Latency from i_response rise to `rsp`: 3 i_clk cycles (2 synchronizer flops + 1 edge flop). o_time and o_valid are registered 1 cycle after `rsp`.
- Latency from i_go rise to TIMING: 2 cycles.
- Measurement resolution is ±1 ms, because the count aligns to the free-running tick.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- REACTION_TIMER_BEST_EN defined:
  - o_best tracks the minimum o_time over valid measurements.
  - It updates in the same cycle o_valid rises, when the new time is less than o_best.
  - False starts and timeouts never update it.
  - Only reset restores it to MAX_MS.
- REACTION_TIMER_BEST_EN undefined: o_best is constant MAX_MS and no register is inferred.

## Structure
- Package reaction_timer_pkg holds:
  - the state enum type (IDLE, ARMED, TIMING, DONE, FAULT);
  - default TIME_W and MAX_MS constants;
  - the synchronizer depth constant (2).
- Sub-module sync_rise: N-flop synchronizer plus rising-edge pulse output. It is instantiated for i_response (depth 2) and for i_go (depth 0).

## Test plan
- Normal measurement: arm; raise go; deliver 250 ticks; raise response → o_valid=1, o_time=250, flags 0, o_busy=0.
- False start: arm; raise response before go → o_falseStart=1, o_valid=0, state FAULT. A later rising edge on go is ignored.
- Simultaneous events:
  - go and response edges in the same cycle → false start.
  - In TIMING, the response edge coincides with the tick after count=99 → o_time=99.
- Timeout: arm; go; 9999 ticks, no response → o_timeout=1, o_time=9999, o_valid=0, o_best unchanged.
- Best tracking (REACTION_TIMER_BEST_EN): measurements of 300, 180, then 220 → o_best = 300, then 180, then 180. With the macro undefined → o_best constant 9999.
- Reset mid-TIMING: assert i_arst at count=40 → all outputs return to their reset values immediately. A fresh arm/go/response sequence then works normally.
